mc_port_arbiter: RTL and testbench
==================================

MC_PORT_ARBITER -- requirements
Module: mc_port_arbiter

Interface
REQ-001 The block SHALL have parameter NPORTS, default 4: number of native user ports, 2..8.
REQ-002 The block SHALL have parameter ADDR_W, default 24: command address width.
REQ-003 The block SHALL have parameter DATA_W, default 256: read data width.
REQ-004 The block SHALL have parameter RD_DEPTH, default 16: read-tag FIFO depth, power of 2.
REQ-005 The block SHALL have port clk  in  1  system clock (one clock); all logic SHALL run on its rising edge.
REQ-006 The block SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-007 The block SHALL have port cmd_valid  in  NPORTS  per-port command request.
REQ-008 The block SHALL have port cmd_ready  out  NPORTS  per-port command accept.
REQ-009 The block SHALL have port cmd_we  in  NPORTS  per-port command type: 1 write, 0 read.
REQ-010 The block SHALL have port cmd_addr  in  NPORTS*ADDR_W  per-port address; port i uses slice i.
REQ-011 The block SHALL have port m_cmd_valid / m_cmd_ready  out / in  1 / 1  merged command handshake toward the bank machines.
REQ-012 The block SHALL have port m_cmd_we / m_cmd_addr / m_cmd_port  out  1 / ADDR_W / clog2(NPORTS)  merged command fields.
REQ-013 The block SHALL have port m_rdata_valid / m_rdata  in  1 / DATA_W  in-order read return from the controller.
REQ-014 The block SHALL have port rdata_valid / rdata  out  NPORTS / DATA_W  per-port read return; rdata is broadcast to all ports.
REQ-015 The block SHALL have port rd_underflow  out  1  sticky error flag.

Function
REQ-016 The block SHALL hold one output register slot (m_cmd_*); the slot is free when m_cmd_valid=0 or m_cmd_ready=1.
REQ-017 The block SHALL grant a round-robin winner each cycle among requesting eligible ports, starting the search at rr_ptr.
REQ-018 A port with cmd_we=0 SHALL be eligible only if tag FIFO count < RD_DEPTH; a write SHALL always be eligible.
REQ-019 cmd_ready SHALL be combinational, one-hot or zero, and SHALL be 1 only for the winner while the slot is free.
REQ-020 On input accept the block SHALL load the slot with we/addr/port of the winner and set m_cmd_valid the next cycle: latency 1.
REQ-021 On input accept rr_ptr SHALL become (winner+1) mod NPORTS; without an accept rr_ptr SHALL be unchanged.
REQ-022 The slot SHALL hold m_cmd_* stable while m_cmd_valid=1 and m_cmd_ready=0.
REQ-023 When the slot drains with no new accept, m_cmd_valid SHALL go to 0.
REQ-024 An accepted read SHALL push its port ID into the tag FIFO in the accept cycle.
REQ-025 When m_rdata_valid=1 and the FIFO is non-empty, the block SHALL pop the FIFO and assert rdata_valid[head]=1 in the same cycle (combinational); rdata SHALL equal m_rdata.
REQ-026 A simultaneous push and pop SHALL leave the count unchanged; the pointers SHALL wrap modulo RD_DEPTH.
REQ-027 When m_rdata_valid=1 and the FIFO is empty, the block SHALL drop the beat, SHALL keep rdata_valid=0, and SHALL set rd_underflow=1 until reset.

Reset
REQ-028 While rst=1 the block SHALL hold m_cmd_valid=0, cmd_ready=0, rdata_valid=0, rr_ptr=0, FIFO empty, and rd_underflow=0.
REQ-029 A reset mid-operation SHALL discard the slot contents and all outstanding tags; data returned after reset with no tags SHALL count as underflow.

Configuration
REQ-030 With the macro MC_ARB_PORT0_PRIO_EN defined, port 0 SHALL win whenever it requests and is eligible, overriding round-robin, and SHALL leave rr_ptr unchanged when it wins.
REQ-031 Without MC_ARB_PORT0_PRIO_EN, all ports SHALL be pure round-robin per REQ-017..REQ-021.

Verification
REQ-032 The bench SHALL cover: NPORTS=4, all ports request continuously, m_cmd_ready=1 -> m_cmd_port sequence 0,1,2,3,0, with one command per cycle.
REQ-033 The bench SHALL cover: m_cmd_ready=0 for 5 cycles with a slot holding port 2 addr 0x000ABC -> fields stable, cmd_ready=0, then the slot drains and the next grant goes to port 3.
REQ-034 The bench SHALL cover: 16 reads from port 1 with no return -> the 17th read stalls (cmd_ready[1]=0) while a port 2 write is still accepted.
REQ-035 The bench SHALL cover: reads from ports 3,0,2, then three m_rdata_valid beats -> rdata_valid one-hot 1000, 0001, 0100 in order.
REQ-036 The bench SHALL cover: m_rdata_valid with the FIFO empty -> rd_underflow=1, with no rdata_valid; rst=1 for one cycle -> rd_underflow=0.
REQ-037 The bench SHALL cover: with MC_ARB_PORT0_PRIO_EN, ports 0 and 1 requesting continuously -> port 0 wins every cycle; port 0 drops its request -> port 1 wins.

Source files
------------

// File: rtl/mc_port_arbiter.sv
// mc_port_arbiter: merges NPORTS native command ports into a single command
// stream toward the bank machines, and routes in-order read data back to the
// port that issued each read.
// - Round-robin grant across eligible requesters into a one-entry output slot.
// - Reads are admitted only while the read-tag FIFO has room; writes always.
// - The read-tag FIFO remembers the issuing port of every accepted read so
//   returned beats can be steered; a beat with no tag sets a sticky error.
// Optional feature: define MC_ARB_PORT0_PRIO_EN to give port 0 absolute
// priority over the round-robin ring (port 0 wins leave rr_ptr untouched).
module mc_port_arbiter #(
  parameter int NPORTS   = 4,
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 256,
  parameter int RD_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NPORTS-1:0]          cmd_valid,
  output logic [NPORTS-1:0]          cmd_ready,
  input  logic [NPORTS-1:0]          cmd_we,
  input  logic [NPORTS*ADDR_W-1:0]   cmd_addr,
  output logic                       m_cmd_valid,
  input  logic                       m_cmd_ready,
  output logic                       m_cmd_we,
  output logic [ADDR_W-1:0]          m_cmd_addr,
  output logic [$clog2(NPORTS)-1:0]  m_cmd_port,
  input  logic                       m_rdata_valid,
  input  logic [DATA_W-1:0]          m_rdata,
  output logic [NPORTS-1:0]          rdata_valid,
  output logic [DATA_W-1:0]          rdata,
  output logic                       rd_underflow
);

  localparam int PW = $clog2(NPORTS);
  localparam int AW = $clog2(RD_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [NPORTS-1:0] ONE_HOT0 = {{(NPORTS-1){1'b0}}, 1'b1};

  logic [PW-1:0]     rr_ptr;
  logic [CW-1:0]     tag_cnt;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [PW-1:0]     tag_mem [RD_DEPTH];

  logic              slot_free;
  logic              rd_room;
  logic [NPORTS-1:0] elig_p0;
  logic              found_p0;
  logic [PW-1:0]     win_p0;
  logic [PW-1:0]     scan_idx;
  logic              sel_we_p0;
  logic [ADDR_W-1:0] sel_addr_p0;
  logic              accept_p0;
  logic              rr_adv;
  logic              push;
  logic              pop;

  // The slot can take a new command if it is empty or draining this cycle.
  assign slot_free = !m_cmd_valid || m_cmd_ready;
  // A read may only be admitted while a tag slot is available for it.
  assign rd_room   = tag_cnt < CW'(RD_DEPTH);
  assign elig_p0   = cmd_valid & (cmd_we | {NPORTS{rd_room}});

  // Winner search: first eligible port scanning upward from rr_ptr.
  always_comb begin
    found_p0 = 1'b0;
    win_p0   = '0;
    scan_idx = '0;
    for (int k = 0; k < NPORTS; k++) begin
      scan_idx = PW'((int'(rr_ptr) + k) % NPORTS);
      if (!found_p0 && elig_p0[scan_idx]) begin
        found_p0 = 1'b1;
        win_p0   = scan_idx;
      end
    end
`ifdef MC_ARB_PORT0_PRIO_EN
    if (elig_p0[0]) begin
      found_p0 = 1'b1;
      win_p0   = '0;
    end
`endif
  end

  // Select the winner's command fields.
  always_comb begin
    sel_we_p0   = 1'b0;
    sel_addr_p0 = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (win_p0 == PW'(i)) begin
        sel_we_p0   = cmd_we[i];
        sel_addr_p0 = cmd_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign accept_p0 = found_p0 && slot_free && !rst;
  assign cmd_ready = accept_p0 ? (ONE_HOT0 << win_p0) : '0;

`ifdef MC_ARB_PORT0_PRIO_EN
  // Priority wins by port 0 do not disturb the ring position of the others.
  assign rr_adv = accept_p0 && (win_p0 != '0);
`else
  assign rr_adv = accept_p0;
`endif

  assign push = accept_p0 && !sel_we_p0;
  assign pop  = m_rdata_valid && (tag_cnt != '0) && !rst;

  // Read return is steered combinationally from the FIFO head tag.
  assign rdata_valid = pop ? (ONE_HOT0 << tag_mem[rd_ptr]) : '0;
  assign rdata       = m_rdata;

  // Control state: slot valid, ring pointer, FIFO pointers/count, error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_cmd_valid  <= 1'b0;
      rr_ptr       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      tag_cnt      <= '0;
      rd_underflow <= 1'b0;
    end else begin
      if (accept_p0) begin
        m_cmd_valid <= 1'b1;
      end else if (m_cmd_ready) begin
        m_cmd_valid <= 1'b0;
      end

      if (rr_adv) begin
        rr_ptr <= (win_p0 == PW'(NPORTS-1)) ? '0 : win_p0 + 1'b1;
      end

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase

      if (m_rdata_valid && (tag_cnt == '0)) begin
        rd_underflow <= 1'b1;
      end
    end
  end

  // Data path: slot fields and tag storage load only on accept, never reset.
  always_ff @(posedge clk) begin
    if (accept_p0) begin
      m_cmd_we   <= sel_we_p0;
      m_cmd_addr <= sel_addr_p0;
      m_cmd_port <= win_p0;
    end
    if (push) begin
      tag_mem[wr_ptr] <= win_p0;
    end
  end

endmodule

// File: tb/tb_mc_port_arbiter.sv
// Bench for mc_port_arbiter (NPORTS=4, RD_DEPTH=16). Expected merged commands
// and read returns are queued by the stimulus and checked by a monitor.
module tb_mc_port_arbiter;

  localparam int NP = 4;
  localparam int AW = 24;
  localparam int DW = 256;
  localparam int RD = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   cmd_valid;
  logic [NP-1:0]   cmd_ready;
  logic [NP-1:0]   cmd_we;
  logic [NP*AW-1:0] cmd_addr;
  logic            m_cmd_valid;
  logic            m_cmd_ready;
  logic            m_cmd_we;
  logic [AW-1:0]   m_cmd_addr;
  logic [1:0]      m_cmd_port;
  logic            m_rdata_valid;
  logic [DW-1:0]   m_rdata;
  logic [NP-1:0]   rdata_valid;
  logic [DW-1:0]   rdata;
  logic            rd_underflow;

  mc_port_arbiter #(
    .NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RD_DEPTH(RD)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_we(m_cmd_we),
    .m_cmd_addr(m_cmd_addr), .m_cmd_port(m_cmd_port),
    .m_rdata_valid(m_rdata_valid), .m_rdata(m_rdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .rd_underflow(rd_underflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] port; logic we; logic [AW-1:0] addr; } cmd_t;
  typedef struct { logic [NP-1:0] oh; logic [DW-1:0] data; } rd_t;

  cmd_t cmd_q[$];
  rd_t  rd_q[$];
  cmd_t mon_c;
  rd_t  mon_r;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic exp_cmd(input int p, input logic we, input logic [AW-1:0] a);
    cmd_t c;
    c.port = 2'(p);
    c.we   = we;
    c.addr = a;
    cmd_q.push_back(c);
  endtask

  task automatic exp_rd(input logic [NP-1:0] oh, input logic [DW-1:0] d);
    rd_t r;
    r.oh   = oh;
    r.data = d;
    rd_q.push_back(r);
  endtask

  task automatic set_addr(input int p, input logic [AW-1:0] a);
    cmd_addr[p*AW +: AW] = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every merged-command transfer and every read return.
  always @(negedge clk) begin
    if (m_cmd_valid === 1'b1 && m_cmd_ready === 1'b1) begin
      if (cmd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m_cmd_unexpected: actual port=%0d addr=%0h required=no transfer",
                 m_cmd_port, m_cmd_addr);
      end else begin
        mon_c = cmd_q.pop_front();
        chk("m_cmd_port", 64'(m_cmd_port), 64'(mon_c.port));
        chk("m_cmd_we",   64'(m_cmd_we),   64'(mon_c.we));
        chk("m_cmd_addr", 64'(m_cmd_addr), 64'(mon_c.addr));
      end
    end
    if ((|rdata_valid) === 1'b1) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdata_unexpected: actual rdata_valid=%b required=0000", rdata_valid);
      end else begin
        mon_r = rd_q.pop_front();
        chk("rdata_valid", 64'(rdata_valid), 64'(mon_r.oh));
        checks++;
        if (rdata !== mon_r.data) begin
          errors++;
          $display("FAIL rdata: actual=%0h required=%0h", rdata[63:0], mon_r.data[63:0]);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int seq [3];
    seq = '{3, 0, 2};

    // Reset state with requests and a read beat present.
    rst = 1'b1;
    cmd_valid = '1;
    cmd_we = '1;
    cmd_addr = '0;
    m_cmd_ready = 1'b1;
    m_rdata_valid = 1'b1;
    m_rdata = '0;
    step();
    @(negedge clk);
    chk("rst_m_cmd_valid", 64'(m_cmd_valid), 64'd0);
    chk("rst_cmd_ready",   64'(cmd_ready),   64'd0);
    chk("rst_rdata_valid", 64'(rdata_valid), 64'd0);
    chk("rst_underflow",   64'(rd_underflow), 64'd0);
    step();
    rst = 1'b0;
    cmd_valid = '0;
    m_rdata_valid = 1'b0;
    for (int i = 0; i < NP; i++) set_addr(i, 24'h000100 + 24'(i));

    // All ports request writes continuously: 0,1,2,3,0 one per cycle.
    cmd_valid = 4'hF;
    cmd_we = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("rr_ready_%0d", k), 64'(cmd_ready), 64'(4'b0001 << (k % 4)));
      exp_cmd(k % 4, 1'b1, 24'h000100 + 24'(k % 4));
      step();
    end
    cmd_valid = '0;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("drain_valid_low", 64'(m_cmd_valid), 64'd0);
    step();

    // Backpressure: slot holds port 2 / 0xABC for 5 cycles, then port 3 wins.
    m_cmd_ready = 1'b0;
    cmd_valid = 4'b0100;
    set_addr(2, 24'h000ABC);
    @(negedge clk);
    chk("bp_accept_p2", 64'(cmd_ready), 64'(4'b0100));
    exp_cmd(2, 1'b1, 24'h000ABC);
    step();
    cmd_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_%0d", k),
          64'({m_cmd_valid, m_cmd_port, m_cmd_addr, cmd_ready}),
          64'({1'b1, 2'd2, 24'h000ABC, 4'b0000}));
      step();
    end
    m_cmd_ready = 1'b1;
    @(negedge clk);
    chk("bp_next_p3", 64'(cmd_ready), 64'(4'b1000));
    exp_cmd(3, 1'b1, 24'h000103);
    step();
    cmd_valid = '0;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("bp_drain_low", 64'(m_cmd_valid), 64'd0);
    step();

    // Sixteen reads from port 1 fill the tag FIFO; the 17th stalls.
    cmd_valid = 4'b0010;
    cmd_we = 4'b0000;
    set_addr(1, 24'h000200);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk($sformatf("fill_ready_%0d", k), 64'(cmd_ready), 64'(4'b0010));
      exp_cmd(1, 1'b0, 24'h000200);
      step();
    end
    cmd_valid = 4'b0110;
    cmd_we = 4'b0100;
    set_addr(2, 24'h000300);
    @(negedge clk);
    chk("full_read_stall_write_ok", 64'(cmd_ready), 64'(4'b0100));
    exp_cmd(2, 1'b1, 24'h000300);
    step();
    cmd_valid = '0;
    for (int k = 0; k < 16; k++) begin
      m_rdata_valid = 1'b1;
      m_rdata = {8{32'hD000_0000 + 32'(k)}};
      exp_rd(4'b0010, {8{32'hD000_0000 + 32'(k)}});
      @(negedge clk);
      step();
    end
    m_rdata_valid = 1'b0;

    // Reads from ports 3,0,2 return in order.
    cmd_we = 4'b0000;
    for (int j = 0; j < 3; j++) begin
      cmd_valid = 4'b0001 << seq[j];
      set_addr(seq[j], 24'h000400 + 24'(seq[j]));
      @(negedge clk);
      chk($sformatf("order_ready_%0d", j), 64'(cmd_ready), 64'(4'b0001 << seq[j]));
      exp_cmd(seq[j], 1'b0, 24'h000400 + 24'(seq[j]));
      step();
    end
    cmd_valid = '0;
    for (int j = 0; j < 3; j++) begin
      m_rdata_valid = 1'b1;
      m_rdata = {8{32'hA000_0000 + 32'(j)}};
      exp_rd(4'b0001 << seq[j], {8{32'hA000_0000 + 32'(j)}});
      @(negedge clk);
      step();
    end
    m_rdata_valid = 1'b0;
    @(negedge clk);
    chk("no_underflow_yet", 64'(rd_underflow), 64'd0);
    step();

    // Beat with empty FIFO: dropped, sticky underflow, cleared by reset.
    m_rdata_valid = 1'b1;
    m_rdata = '1;
    @(negedge clk);
    chk("empty_beat_rdata_valid", 64'(rdata_valid), 64'd0);
    step();
    m_rdata_valid = 1'b0;
    @(negedge clk);
    chk("underflow_set", 64'(rd_underflow), 64'd1);
    step();
    @(negedge clk);
    chk("underflow_sticky", 64'(rd_underflow), 64'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("underflow_cleared", 64'(rd_underflow), 64'd0);
    step();

    // Reset mid-operation discards the held slot and the outstanding tag.
    m_cmd_ready = 1'b0;
    cmd_valid = 4'b0001;
    set_addr(0, 24'h000500);
    @(negedge clk);
    chk("mid_accept_p0", 64'(cmd_ready), 64'(4'b0001));
    step();
    cmd_valid = '0;
    @(negedge clk);
    chk("mid_slot_held", 64'(m_cmd_valid), 64'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_slot_discarded", 64'(m_cmd_valid), 64'd0);
    step();
    m_cmd_ready = 1'b1;
    m_rdata_valid = 1'b1;
    @(negedge clk);
    chk("mid_tag_discarded", 64'(rdata_valid), 64'd0);
    step();
    m_rdata_valid = 1'b0;
    @(negedge clk);
    chk("mid_underflow", 64'(rd_underflow), 64'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Ports 0 and 1 requesting continuously.
    cmd_we = 4'hF;
    cmd_valid = 4'b0011;
    set_addr(0, 24'h000600);
    set_addr(1, 24'h000601);
`ifdef MC_ARB_PORT0_PRIO_EN
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("prio_p0_%0d", k), 64'(cmd_ready), 64'(4'b0001));
      exp_cmd(0, 1'b1, 24'h000600);
      step();
    end
    cmd_valid = 4'b0010;
    @(negedge clk);
    chk("prio_p1_after_drop", 64'(cmd_ready), 64'(4'b0010));
    exp_cmd(1, 1'b1, 24'h000601);
    step();
`else
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rr_pair_%0d", k), 64'(cmd_ready), 64'(4'b0001 << (k % 2)));
      exp_cmd(k % 2, 1'b1, 24'h000600 + 24'(k % 2));
      step();
    end
`endif
    cmd_valid = '0;
    repeat (3) begin
      @(negedge clk);
      step();
    end

    chk("cmd_q_empty", 64'(cmd_q.size()), 64'd0);
    chk("rd_q_empty",  64'(rd_q.size()),  64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
